// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: register offsets, FSM states, VEC layout.
// No logic and no latency; imported by the arbiter, its sub-modules and benches.
package irq_pkg;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_VEC  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_SVC  = 2'b10
  } state_t;

  localparam int VEC_VALID_BIT = 31;
  localparam int ID_W          = 6;

  function automatic logic [31:0] pack_vec(input logic valid, input logic [ID_W-1:0] id);
    logic [31:0] v;
    v                = '0;
    v[VEC_VALID_BIT] = valid;
    v[ID_W-1:0]      = id;
    return v;
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Peripheral-bus register port plus interrupt source/CPU handshake lines of the arbiter.
// Single-cycle bus (no wait states); int_ack/int_done are one-cycle pulses from the CPU.
interface irq_arbiter_if #(
  parameter int N_SRC = 6
);
  logic [31:2]      Addr;
  logic             WE;
  logic [31:0]      Din;
  logic [31:0]      Dout;
  logic [N_SRC-1:0] irq_src;
  logic             int_ack;
  logic             int_done;
  logic             IRQ;

  modport master (
    output Addr, WE, Din, irq_src, int_ack, int_done,
    input  Dout, IRQ
  );

  modport slave (
    input  Addr, WE, Din, irq_src, int_ack, int_done,
    output Dout, IRQ
  );
endinterface

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
// Purely combinational, zero latency, no backpressure.
module prio_enc #(
  parameter int N = 6,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);

  // Scanning downward lets the lowest set bit overwrite the result last.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: mask/edge/pend registers, fixed-priority pick, REQ/ack/service FSM.
// IRQ rises 2 cycles after a source change; register writes never stall the FSM.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic           clk,
  input  logic           reset,
  irq_arbiter_if.slave   bus
);

  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] edge_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic             any;
  logic [ID_W-1:0]  win;
  logic             take;
  logic             vec_valid;
  logic [ID_W-1:0]  vec_id;
  logic             wr_mask;
  logic             wr_edge;
  logic             wr_pend;
  logic             unused_bits;
  state_t           state;
  state_t           state_nxt;

  assign wr_mask = bus.WE && (bus.Addr[3:2] == REG_MASK);
  assign wr_edge = bus.WE && (bus.Addr[3:2] == REG_EDGE);
  assign wr_pend = bus.WE && (bus.Addr[3:2] == REG_PEND);

  assign act = pend_q & mask_q;

  prio_enc #(
    .N (N_SRC),
    .W (ID_W)
  ) u_prio (
    .req (act),
    .any (any),
    .idx (win)
  );

  assign take    = (state == S_REQ) && bus.int_ack && any;
  assign rise    = bus.irq_src & ~src_q;
  assign w1c     = wr_pend ? bus.Din[N_SRC-1:0] : '0;
  assign ack_clr = take ? (N_SRC'(1) << win) : '0;

  // Edge bits: a new rising edge beats any clear in the same cycle.
  // Level bits simply track the source and ignore W1C and ack.
  assign pend_d = (edge_q & (rise | (pend_q & ~(w1c | ack_clr))))
                | (~edge_q & bus.irq_src);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (any) state_nxt = S_REQ;
      S_REQ: begin
        if (!any)             state_nxt = S_IDLE;
        else if (bus.int_ack) state_nxt = S_SVC;
      end
      S_SVC:   if (bus.int_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      edge_q    <= '0;
      pend_q    <= '0;
      src_q     <= '0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
    end else begin
      src_q  <= bus.irq_src;
      pend_q <= pend_d;
      if (wr_mask) mask_q <= bus.Din[N_SRC-1:0];
      if (wr_edge) edge_q <= bus.Din[N_SRC-1:0];
      if (take) begin
        vec_valid <= 1'b1;
        vec_id    <= win;
      end else if ((state == S_SVC) && bus.int_done) begin
        vec_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.Dout = '0;
    unique case (bus.Addr[3:2])
      REG_MASK: bus.Dout = 32'(mask_q);
      REG_EDGE: bus.Dout = 32'(edge_q);
      REG_PEND: bus.Dout = 32'(pend_q);
      REG_VEC:  bus.Dout = pack_vec(vec_valid, vec_id);
      default:  bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = (state == S_REQ);

  assign unused_bits = ^{bus.Addr[31:4], bus.Din[31:N_SRC]};

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios then random traffic against a per-bit reference model.
module tb_irq_arbiter;
  import irq_pkg::*;

  localparam int N = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_arbiter_if #(.N_SRC(N)) bus();

  irq_arbiter #(.N_SRC(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one flag per source, state as 0=idle 1=requesting 2=in service.
  bit m_mask [N];
  bit m_edge [N];
  bit m_pend [N];
  bit m_srcq [N];
  int m_state;
  bit m_vvalid;
  int m_vid;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mask[i] = 0; m_edge[i] = 0; m_pend[i] = 0; m_srcq[i] = 0;
    end
    m_state  = 0;
    m_vvalid = 0;
    m_vid    = 0;
  endtask

  function automatic logic [31:0] model_reg(input int a);
    logic [31:0] r;
    logic [31:0] id;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (a == 0) r[i] = m_mask[i];
      if (a == 1) r[i] = m_edge[i];
      if (a == 2) r[i] = m_pend[i];
    end
    if (a == 3) begin
      id       = m_vid;
      r[31]    = m_vvalid;
      r[5:0]   = id[5:0];
    end
    return r;
  endfunction

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    int win;
    int a;
    int nstate;
    bit take;
    bit np [N];
    a   = int'(bus.Addr[3:2]);
    win = -1;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && m_mask[i]) begin
        win = i;
        break;
      end
    end
    take = (m_state == 1) && bus.int_ack && (win >= 0);
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) begin
        if (bus.irq_src[i] && !m_srcq[i])                       np[i] = 1;
        else if ((bus.WE && a == 2 && bus.Din[i]) || (take && win == i)) np[i] = 0;
        else                                                    np[i] = m_pend[i];
      end else begin
        np[i] = bus.irq_src[i];
      end
    end
    nstate = m_state;
    if (m_state == 0 && win >= 0) nstate = 1;
    else if (m_state == 1 && win < 0) nstate = 0;
    else if (m_state == 1 && bus.int_ack) nstate = 2;
    else if (m_state == 2 && bus.int_done) nstate = 0;
    if (take) begin
      m_vvalid = 1;
      m_vid    = win;
    end else if (m_state == 2 && bus.int_done) begin
      m_vvalid = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.WE && a == 0) m_mask[i] = bus.Din[i];
      if (bus.WE && a == 1) m_edge[i] = bus.Din[i];
      m_srcq[i] = bus.irq_src[i];
      m_pend[i] = np[i];
    end
    m_state = nstate;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int a, input logic [31:0] exp);
    bus.Addr = 30'(a);
    #1;
    check(tag, bus.Dout, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_irq"}, 32'(bus.IRQ), 32'(m_state == 1));
    for (int a = 0; a < 4; a++) check_reg($sformatf("%s_r%0d", tag, a), a, model_reg(a));
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.Addr = 30'(a);
    bus.WE   = 1'b1;
    bus.Din  = d;
    tick();
    bus.WE   = 1'b0;
    bus.Din  = '0;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.Addr     = '0;
    bus.WE       = 1'b0;
    bus.Din      = '0;
    bus.irq_src  = '0;
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_irq", 32'(bus.IRQ), 32'h0);
    check_reg("rst_mask", 0, 32'h0);
    check_reg("rst_edge", 1, 32'h0);
    check_reg("rst_pend", 2, 32'h0);
    check_reg("rst_vec", 3, 32'h0);

    // Single edge source through the full request/ack/done sequence.
    wr(0, 32'h1);
    wr(1, 32'h1);
    bus.irq_src = 6'h01;
    tick();
    bus.irq_src = '0;
    check("t1_irq_e0", 32'(bus.IRQ), 32'h0);
    check_reg("t1_pend_set", 2, 32'h1);
    tick();
    check("t1_irq_e1", 32'(bus.IRQ), 32'h1);
    pulse_ack();
    check("t1_irq_ack", 32'(bus.IRQ), 32'h0);
    check_reg("t1_vec_ack", 3, 32'h8000_0000);
    check_reg("t1_pend_ack", 2, 32'h0);
    pulse_done();
    check_reg("t1_vec_done", 3, 32'h0000_0000);
    check_model("t1");

    // Two simultaneous edges: lowest index first, second after the return to idle.
    wr(0, 32'h3F);
    wr(1, 32'h3F);
    bus.irq_src = 6'h12;
    tick();
    bus.irq_src = '0;
    tick();
    check("t2_irq", 32'(bus.IRQ), 32'h1);
    pulse_ack();
    check_reg("t2_vec1", 3, 32'h8000_0001);
    check_reg("t2_pend1", 2, 32'h10);
    pulse_done();
    check("t2_irq_gap", 32'(bus.IRQ), 32'h0);
    tick();
    check("t2_irq_again", 32'(bus.IRQ), 32'h1);
    pulse_ack();
    check_reg("t2_vec4", 3, 32'h8000_0004);
    pulse_done();
    check_model("t2");

    // Level source: W1C ignored, dropping the source withdraws the request.
    wr(1, 32'h0);
    wr(0, 32'h04);
    bus.irq_src = 6'h04;
    tick();
    check("t3_irq_e0", 32'(bus.IRQ), 32'h0);
    tick();
    check("t3_irq_e1", 32'(bus.IRQ), 32'h1);
    wr(2, 32'h04);
    check_reg("t3_pend_w1c", 2, 32'h04);
    check("t3_irq_w1c", 32'(bus.IRQ), 32'h1);
    bus.irq_src = '0;
    tick();
    check("t3_irq_drop1", 32'(bus.IRQ), 32'h1);
    tick();
    check("t3_irq_drop2", 32'(bus.IRQ), 32'h0);
    pulse_ack();
    check("t3_irq_noack", 32'(bus.IRQ), 32'h0);
    check_reg("t3_vec_noack", 3, 32'h0000_0004);
    check_model("t3");

    // Edge set and W1C of the same bit in one cycle: the set wins.
    wr(1, 32'h3F);
    bus.irq_src = 6'h08;
    wr(2, 32'h08);
    bus.irq_src = '0;
    check_reg("t4_pend_race", 2, 32'h08);
    wr(2, 32'h08);
    check_reg("t4_pend_clr", 2, 32'h0);

    // Masking a pending request withdraws it; unmasking brings it back.
    wr(0, 32'h0);
    bus.irq_src = 6'h20;
    tick();
    bus.irq_src = '0;
    check_reg("t5_pend", 2, 32'h20);
    wr(0, 32'h3F);
    check("t5_irq_unmask0", 32'(bus.IRQ), 32'h0);
    tick();
    check("t5_irq_unmask1", 32'(bus.IRQ), 32'h1);
    wr(0, 32'h0);
    check("t5_irq_mask0", 32'(bus.IRQ), 32'h1);
    tick();
    check("t5_irq_mask1", 32'(bus.IRQ), 32'h0);
    check_reg("t5_pend_kept", 2, 32'h20);
    wr(0, 32'h3F);
    tick();
    check("t5_irq_restore", 32'(bus.IRQ), 32'h1);

    // Asynchronous reset in the middle of service.
    bus.irq_src = 6'h01;
    tick();
    bus.irq_src = '0;
    pulse_ack();
    check_reg("t6_vec", 3, 32'h8000_0000);
    bus.irq_src = 6'h01;
    tick();
    bus.irq_src = '0;
    check_reg("t6_pend", 2, 32'h21);
    check("t6_irq_svc", 32'(bus.IRQ), 32'h0);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_rst_irq", 32'(bus.IRQ), 32'h0);
    check_reg("t6_rst_mask", 0, 32'h0);
    check_reg("t6_rst_edge", 1, 32'h0);
    check_reg("t6_rst_pend", 2, 32'h0);
    check_reg("t6_rst_vec", 3, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic against the reference model.
    wr(0, 32'h3F);
    wr(1, 32'h2A);
    for (int c = 0; c < 2000; c++) begin
      bus.irq_src  = N'($urandom & $urandom);
      bus.WE       = ($urandom_range(0, 5) == 0);
      bus.Addr     = 30'($urandom_range(0, 3));
      bus.Din      = $urandom;
      bus.int_ack  = ($urandom_range(0, 2) == 0);
      bus.int_done = ($urandom_range(0, 3) == 0);
      tick();
      bus.WE       = 1'b0;
      bus.int_ack  = 1'b0;
      bus.int_done = 1'b0;
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt arbiter that collects interrupt requests from the system timers and other peripherals, applies per-source mask and trigger mode, and presents one interrupt line plus a vector to the CPU. It sits on the peripheral bus beside the timers as a memory-mapped device. It sequences each interrupt through request, acknowledge and service, and holds off further requests until software signals completion.

## Interface
- N_SRC, 6, number of interrupt sources (1..30); bit i of every per-source register maps to irq_src[i]
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- Addr  in  [31:2]  word address; only Addr[3:2] decoded
- WE  in  1  register write strobe, qualified by the external address decoder
- Din  in  32  write data
- Dout  out  32  read data, combinational from Addr[3:2]
- irq_src  in  N_SRC  peripheral requests, synchronous to clk; timer IRQs connect here
- int_ack  in  1  CPU took the interrupt (exception entry), one-cycle pulse
- int_done  in  1  handler finished (eret), one-cycle pulse
- IRQ  out  1  interrupt request to CPU; reset 0

## Operation
- Register map (Addr[3:2]):
  - 0 MASK, RW: 1 = source enabled.
  - 1 EDGE, RW: 1 = rising-edge/sticky, 0 = level.
  - 2 PEND, R and write-1-to-clear.
  - 3 VEC, RO: {valid[31], 25'b0, id[5:0]}.
- Bits above N_SRC read 0 and ignore writes. Writes to VEC are ignored. All registers reset to 0.
- Edge sources:
  - src_q holds irq_src delayed one cycle.
  - PEND[i] sets on irq_src[i] & ~src_q[i].
  - It clears on a W1C write or when source i is acknowledged.
  - If set and clear fall in the same cycle, set wins.
- Level sources: PEND[i] = irq_src[i], registered every cycle. W1C and ack have no effect; software must clear the source, for example the timer's ctrl.
- Active set: act = PEND & MASK. Winner is the lowest set index in act (fixed priority, bit 0 highest).
- FSM states:
  - IDLE → REQ when act ≠ 0.
  - REQ → IDLE when act becomes 0 (withdrawn by mask change or level drop).
  - REQ → SERVICE on int_ack with act ≠ 0. In the same edge: VEC <= {1, winner}, and the winner's PEND bit clears if it is edge-mode.
  - SERVICE → IDLE on int_done; VEC.valid clears and id is retained.
- IRQ = (state == REQ), decoded directly from the state register.
- Ignored events:
  - int_ack outside REQ.
  - int_ack in REQ when act = 0 in that same cycle; the FSM goes to IDLE instead.
  - int_done outside SERVICE.
- No nesting: while in SERVICE, new pending bits accumulate and are arbitrated after return to IDLE.
- Register writes are processed in parallel with the FSM. They do not stall it.

## Timing
- Edge source goes high before edge E0: PEND set at E0, state REQ at E1, so IRQ is high from E1. Latency is 2 cycles from the source change.
- Level source uses the same 2-cycle latency.
- MASK write at E0 that clears the only active source while in REQ: IRQ low from E1.
- int_ack sampled at E0: IRQ low from E0, VEC valid from E0.
- int_done at E0: IDLE at E0. If act ≠ 0, IRQ is high again from E1, giving a minimum 1-cycle IRQ gap.
- Reset asserted mid-operation: state IDLE, IRQ 0, all registers 0 immediately. src_q clears, so a source held high across reset release is seen as an edge on the first clock.

## Structure
- Shared package `irq_pkg`:
  - register offsets REG_MASK=0, REG_EDGE=1, REG_PEND=2, REG_VEC=3
  - FSM state encoding S_IDLE=2'b00, S_REQ=2'b01, S_SVC=2'b10
  - VEC valid bit position
- Sub-module `prio_enc`, parameterized on N_SRC: input vector → {any, lowest set index}. It is purely combinational and reusable by later arbiters.
- Top module contains: register file, edge detect, FSM, read mux.

## Test plan
- Reset, then MASK=1, EDGE=1; pulse irq_src[0] for 1 cycle → IRQ high 2 cycles later. int_ack → IRQ 0, VEC=32'h8000_0000, PEND=0. int_done → VEC=32'h0000_0000.
- MASK=6'h3F, EDGE=6'h3F; raise src[4] and src[1] in the same cycle → ack gives VEC id 1, PEND=6'h10. After done, IRQ returns 1 cycle later; next ack gives id 4.
- Level mode, MASK=6'h04, timer IRQ on src[2] held high → IRQ high. Write PEND=6'h04 → no change. Drop src[2] in REQ → IRQ low 2 cycles later; int_ack afterward is ignored and VEC.valid=0.
- Edge set on src[3] in the same cycle as W1C of PEND bit 3 → PEND[3]=1 remains.
- In REQ, write MASK=0 → IRQ low next cycle. PEND is kept; restoring MASK re-raises IRQ.
- Assert reset while in SERVICE with PEND=6'h21 → IRQ=0, all registers 0, FSM IDLE with no clock edge required.
